pipeline_mem_stage: RTL and testbench
=====================================

Name: pipeline_mem_stage

Overview:
Memory-access stage of the 5-stage RV64 pipeline. It sits between the execute stage and the write-back stage.
- Registers the EX bundle and performs loads/stores over a request/acknowledge data-memory port.
- Aligns store data into byte lanes and sign- or zero-extends load data.
- Presents alu_result_MEM, mem_data_MEM, rd_MEM, reg_write_MEM, rf_wr_sel_MEM and pc_MEM to write-back.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
DMEM_TIMEOUT, 0, cycles to wait for dmem_ack before aborting; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_EX  in  1  the EX bundle holds a real instruction
alu_result_EX  in  64  ALU result / effective address
rs2_data_EX  in  64  store data
rd_EX  in  5  destination register
reg_write_EX  in  1  register write enable
rf_wr_sel_EX  in  2  write-back select: 00 zero, 01 pc+4, 10 ALU, 11 memory
mem_read_EX  in  1  load
mem_write_EX  in  1  store
funct3_EX  in  3  access size/sign
pc_EX  in  64  instruction PC
stall_MEM  out  1  freeze IF/ID/EX
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  64  doubleword-aligned address {addr[63:3],3'b000}
dmem_wdata  out  64  lane-shifted store data
dmem_wstrb  out  8  byte strobes
dmem_rdata  in  64  read data, valid with ack
dmem_ack  in  1  access complete
alu_result_MEM  out  64  to WB
mem_data_MEM  out  64  extended load data
rd_MEM  out  5  to WB
reg_write_MEM  out  1  one-cycle pulse per retired instruction
rf_wr_sel_MEM  out  2  to WB
pc_MEM  out  64  to WB
dmem_err_MEM  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (synchronous):
  - FSM goes to IDLE.
  - Every output and holding register clears to 0, including dmem_req, stall_MEM and reg_write_MEM.
  - Reset during ACCESS drops dmem_req the next edge. A late ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, valid_EX=1, no memory op:
  - Capture the bundle.
  - Next cycle, drive the *_MEM outputs with reg_write_MEM=reg_write_EX.
  - Latency 1. FSM stays in IDLE.
- IDLE, valid_EX=1, mem_read_EX or mem_write_EX set:
  - Capture the bundle, go to ACCESS, assert dmem_req next cycle.
  - stall_MEM=1 combinationally in ACCESS until the ack cycle.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb stay stable until dmem_ack=1 is sampled.
  - On the ack edge: FSM returns to IDLE and the *_MEM outputs update (load data from dmem_rdata).
  - stall_MEM drops in the ack cycle, so the next EX bundle is accepted the same edge.
  - Latency is 1 + number of ACCESS cycles (at least 2 for memory ops).
- valid_EX=0, or any cycle not completing an instruction: reg_write_MEM=0 (bubble). Other *_MEM outputs hold their values.
- Mem op with both read and write set: treated as a load.
- Store, with off = addr[2:0]:
  - funct3 000 SB: wstrb = 0x01 << off, byte replicated across lanes.
  - 001 SH: wstrb = 0x03 << off.
  - 010 SW: wstrb = 0x0F << off.
  - 011 SD: wstrb = 0xFF.
  - wdata = rs2_data_EX << (8*off).
  - reg_write_MEM follows reg_write_EX (normally 0).
- Load: shift = dmem_rdata >> (8*off).
  - 000 LB / 001 LH / 010 LW: sign-extend 8/16/32 bits.
  - 011 LD: full 64 bits.
  - 100 LBU / 101 LHU / 110 LWU: zero-extend.
  - 111: result 0.
- Misalignment without the feature: off is masked to natural alignment (LH/SH clear bit 0, W clears [1:0], D clears [2:0]) before use.
- Timeout (DMEM_TIMEOUT > 0):
  - After DMEM_TIMEOUT ACCESS cycles with no ack: return to IDLE, pulse dmem_err_MEM, reg_write_MEM=0.
  - Ack and timeout in the same cycle: ack wins.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned access (H off odd, W off[1:0]≠0, D off≠0) issues no dmem_req and does not enter ACCESS.
  - Completes in 1 cycle with reg_write_MEM=0.
  - Adds output misalign_MEM (1 bit) pulsing 1 with the offending pc_MEM.
- Undefined: the port is absent and address masking applies.

Test Plan:
- Reset high for 2 cycles mid-ACCESS → dmem_req=0, stall_MEM=0, reg_write_MEM=0 next edge; ack on the following cycle causes no output change.
- ALU op rd=5, alu_result=0x1234, rf_wr_sel=10 → one cycle later rd_MEM=5, alu_result_MEM=0x1234, reg_write_MEM=1 for exactly 1 cycle; stall_MEM never asserts.
- LB at addr 0x1003, ack after 3 cycles, rdata=0x00000000_80000000 → stall_MEM high 2 cycles, mem_data_MEM=0xFFFFFFFF_FFFFFF80; same with LBU → 0x80.
- SH at 0x2006, rs2=0xABCD → dmem_addr=0x2000, wstrb=0xC0, wdata=0xABCD_0000_0000_0000, dmem_we=1.
- Back-to-back: load then ALU op with ack in the first ACCESS cycle → ALU op retires exactly one cycle after the load; no bubble lost, no duplicate reg_write_MEM.
- DMEM_TIMEOUT=4, no ack → dmem_err_MEM pulses after 4 ACCESS cycles, reg_write_MEM stays 0. With MISALIGN_TRAP_EN, LW at 0x1002 → misalign_MEM=1, dmem_req stays 0.

Source files
------------

// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the 5-stage RV64 pipeline.
// Registers the EX bundle, runs loads/stores over a req/ack data-memory port,
// lane-aligns store data, extends load data and stalls upstream while an access
// is outstanding.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned accesses are not issued and
// are flagged on misalign_MEM; without it the offset is masked to natural alignment.
module pipeline_mem_stage #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_EX,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [XLEN-1:0] rs2_data_EX,
    input  logic [4:0]      rd_EX,
    input  logic            reg_write_EX,
    input  logic [1:0]      rf_wr_sel_EX,
    input  logic            mem_read_EX,
    input  logic            mem_write_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [XLEN-1:0] pc_EX,
    output logic            stall_MEM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [XLEN-1:0] alu_result_MEM,
    output logic [XLEN-1:0] mem_data_MEM,
    output logic [4:0]      rd_MEM,
    output logic            reg_write_MEM,
    output logic [1:0]      rf_wr_sel_MEM,
    output logic [XLEN-1:0] pc_MEM,
    output logic            dmem_err_MEM
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_MEM
`endif
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e          state_q;
    // An instruction accepted on a completion edge waits here one cycle.
    logic            pend_q;
    logic [XLEN-1:0] hold_alu_q, hold_rs2_q, hold_pc_q;
    logic [4:0]      hold_rd_q;
    logic            hold_reg_write_q, hold_read_q, hold_write_q;
    logic [1:0]      hold_rf_wr_sel_q;
    logic [2:0]      hold_funct3_q;
    logic [2:0]      hold_off_q;
    logic [31:0]     tmo_cnt_q;

    logic            in_valid, in_mem, trap, timeout_hit, done;
    logic [XLEN-1:0] in_alu, in_rs2, in_pc;
    logic [4:0]      in_rd;
    logic            in_reg_write, in_read, in_write;
    logic [1:0]      in_rf_wr_sel;
    logic [2:0]      in_funct3, off_mask, off_m;
    logic [7:0]      in_strb;
    logic [XLEN-1:0] in_wdata, ld_shift, ld_data;

    assign timeout_hit = (DMEM_TIMEOUT != 0) && (tmo_cnt_q == DMEM_TIMEOUT - 1);
    assign done        = (state_q == StAccess) && (dmem_ack || timeout_hit);
    assign stall_MEM   = ((state_q == StAccess) && !done) || pend_q;
    assign in_valid    = (state_q == StIdle) && (pend_q || valid_EX);
    assign in_mem      = in_read || in_write;

    // Select the instruction entering the stage: the parked one has priority.
    always_comb begin
        if (pend_q) begin
            in_alu       = hold_alu_q;
            in_rs2       = hold_rs2_q;
            in_pc        = hold_pc_q;
            in_rd        = hold_rd_q;
            in_reg_write = hold_reg_write_q;
            in_rf_wr_sel = hold_rf_wr_sel_q;
            in_read      = hold_read_q;
            in_write     = hold_write_q;
            in_funct3    = hold_funct3_q;
        end else begin
            in_alu       = alu_result_EX;
            in_rs2       = rs2_data_EX;
            in_pc        = pc_EX;
            in_rd        = rd_EX;
            in_reg_write = reg_write_EX;
            in_rf_wr_sel = rf_wr_sel_EX;
            in_read      = mem_read_EX;
            in_write     = mem_write_EX;
            in_funct3    = funct3_EX;
        end
    end

    // Byte offset, alignment mask, store strobes and lane-shifted store data.
    always_comb begin
        off_mask = 3'b111;
        in_strb  = 8'h00;
        unique case (in_funct3[1:0])
            2'b00: off_mask = 3'b111;
            2'b01: off_mask = 3'b110;
            2'b10: off_mask = 3'b100;
            2'b11: off_mask = 3'b000;
        endcase
        off_m = in_alu[2:0] & off_mask;
        unique case (in_funct3[1:0])
            2'b00: in_strb = 8'h01 << off_m;
            2'b01: in_strb = 8'h03 << off_m;
            2'b10: in_strb = 8'h0F << off_m;
            2'b11: in_strb = 8'hFF;
        endcase
        if (in_funct3[1:0] == 2'b00) begin
            in_wdata = {(XLEN/8){in_rs2[7:0]}};
        end else begin
            in_wdata = in_rs2 << {off_m, 3'b000};
        end
`ifdef MISALIGN_TRAP_EN
        trap = in_mem && ((in_alu[2:0] & ~off_mask) != 3'b000);
`else
        trap = 1'b0;
`endif
    end

    // Extract the addressed lanes of the read data and extend per funct3.
    always_comb begin
        ld_shift = dmem_rdata >> {hold_off_q, 3'b000};
        case (hold_funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_data = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            3'b011:  ld_data = ld_shift;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            3'b110:  ld_data = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
            default: ld_data = '0;
        endcase
    end

    // FSM, holding registers, memory port and write-back outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            pend_q           <= 1'b0;
            hold_alu_q       <= '0;
            hold_rs2_q       <= '0;
            hold_pc_q        <= '0;
            hold_rd_q        <= '0;
            hold_reg_write_q <= 1'b0;
            hold_rf_wr_sel_q <= '0;
            hold_read_q      <= 1'b0;
            hold_write_q     <= 1'b0;
            hold_funct3_q    <= '0;
            hold_off_q       <= '0;
            tmo_cnt_q        <= '0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_wstrb       <= '0;
            alu_result_MEM   <= '0;
            mem_data_MEM     <= '0;
            rd_MEM           <= '0;
            reg_write_MEM    <= 1'b0;
            rf_wr_sel_MEM    <= '0;
            pc_MEM           <= '0;
            dmem_err_MEM     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_MEM     <= 1'b0;
`endif
        end else begin
            reg_write_MEM <= 1'b0;
            dmem_err_MEM  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_MEM  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        pend_q           <= 1'b0;
                        hold_alu_q       <= in_alu;
                        hold_rs2_q       <= in_rs2;
                        hold_pc_q        <= in_pc;
                        hold_rd_q        <= in_rd;
                        hold_reg_write_q <= in_reg_write;
                        hold_rf_wr_sel_q <= in_rf_wr_sel;
                        hold_read_q      <= in_read;
                        hold_write_q     <= in_write;
                        hold_funct3_q    <= in_funct3;
                        hold_off_q       <= off_m;
                        if (in_mem && !trap) begin
                            state_q    <= StAccess;
                            tmo_cnt_q  <= '0;
                            dmem_req   <= 1'b1;
                            // Read wins when both read and write are set.
                            dmem_we    <= in_write && !in_read;
                            dmem_addr  <= {in_alu[XLEN-1:3], 3'b000};
                            dmem_wdata <= in_read ? '0 : in_wdata;
                            dmem_wstrb <= in_read ? 8'h00 : in_strb;
                        end else begin
                            alu_result_MEM <= in_alu;
                            rd_MEM         <= in_rd;
                            rf_wr_sel_MEM  <= in_rf_wr_sel;
                            pc_MEM         <= in_pc;
                            reg_write_MEM  <= in_reg_write && !trap;
`ifdef MISALIGN_TRAP_EN
                            misalign_MEM   <= trap;
`endif
                        end
                    end
                end
                StAccess: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    if (done) begin
                        state_q  <= StIdle;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc_MEM   <= hold_pc_q;
                        // Ack wins over a simultaneous timeout.
                        if (dmem_ack) begin
                            alu_result_MEM <= hold_alu_q;
                            rd_MEM         <= hold_rd_q;
                            rf_wr_sel_MEM  <= hold_rf_wr_sel_q;
                            reg_write_MEM  <= hold_reg_write_q;
                            if (hold_read_q) mem_data_MEM <= ld_data;
                        end else begin
                            dmem_err_MEM <= 1'b1;
                        end
                        // Upstream advances this edge, so park the EX bundle.
                        if (valid_EX) begin
                            pend_q           <= 1'b1;
                            hold_alu_q       <= alu_result_EX;
                            hold_rs2_q       <= rs2_data_EX;
                            hold_pc_q        <= pc_EX;
                            hold_rd_q        <= rd_EX;
                            hold_reg_write_q <= reg_write_EX;
                            hold_rf_wr_sel_q <= rf_wr_sel_EX;
                            hold_read_q      <= mem_read_EX;
                            hold_write_q     <= mem_write_EX;
                            hold_funct3_q    <= funct3_EX;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: one default instance and one with a
// 4-cycle memory timeout (its ack tied low).
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_EX, reg_write_EX, mem_read_EX, mem_write_EX, dmem_ack;
    logic [63:0] alu_result_EX, rs2_data_EX, pc_EX, dmem_rdata;
    logic [4:0]  rd_EX;
    logic [1:0]  rf_wr_sel_EX;
    logic [2:0]  funct3_EX;

    logic        stall_MEM, dmem_req, dmem_we, reg_write_MEM, dmem_err_MEM;
    logic [63:0] dmem_addr, dmem_wdata, alu_result_MEM, mem_data_MEM, pc_MEM;
    logic [7:0]  dmem_wstrb;
    logic [4:0]  rd_MEM;
    logic [1:0]  rf_wr_sel_MEM;

    logic        to_stall, to_req, to_we, to_reg_write, to_err;
    logic [63:0] to_addr, to_wdata, to_alu, to_mem_data, to_pc;
    logic [7:0]  to_wstrb;
    logic [4:0]  to_rd;
    logic [1:0]  to_sel;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_MEM, to_misalign;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    pipeline_mem_stage dut (
        .clk(clk), .reset(reset), .valid_EX(valid_EX), .alu_result_EX(alu_result_EX),
        .rs2_data_EX(rs2_data_EX), .rd_EX(rd_EX), .reg_write_EX(reg_write_EX),
        .rf_wr_sel_EX(rf_wr_sel_EX), .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
        .funct3_EX(funct3_EX), .pc_EX(pc_EX), .stall_MEM(stall_MEM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_result_MEM(alu_result_MEM), .mem_data_MEM(mem_data_MEM), .rd_MEM(rd_MEM),
        .reg_write_MEM(reg_write_MEM), .rf_wr_sel_MEM(rf_wr_sel_MEM), .pc_MEM(pc_MEM),
        .dmem_err_MEM(dmem_err_MEM)
`ifdef MISALIGN_TRAP_EN
        , .misalign_MEM(misalign_MEM)
`endif
    );

    pipeline_mem_stage #(.DMEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .valid_EX(valid_EX), .alu_result_EX(alu_result_EX),
        .rs2_data_EX(rs2_data_EX), .rd_EX(rd_EX), .reg_write_EX(reg_write_EX),
        .rf_wr_sel_EX(rf_wr_sel_EX), .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
        .funct3_EX(funct3_EX), .pc_EX(pc_EX), .stall_MEM(to_stall), .dmem_req(to_req),
        .dmem_we(to_we), .dmem_addr(to_addr), .dmem_wdata(to_wdata),
        .dmem_wstrb(to_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(1'b0),
        .alu_result_MEM(to_alu), .mem_data_MEM(to_mem_data), .rd_MEM(to_rd),
        .reg_write_MEM(to_reg_write), .rf_wr_sel_MEM(to_sel), .pc_MEM(to_pc),
        .dmem_err_MEM(to_err)
`ifdef MISALIGN_TRAP_EN
        , .misalign_MEM(to_misalign)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        valid_EX = 1'b0; mem_read_EX = 1'b0; mem_write_EX = 1'b0; reg_write_EX = 1'b0;
        funct3_EX = 3'b000; rd_EX = 5'd0; alu_result_EX = '0; rs2_data_EX = '0;
        rf_wr_sel_EX = 2'b00; pc_EX = '0;
    endtask

    task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                           input logic [63:0] pc);
        valid_EX = 1'b1; mem_read_EX = rd_op; mem_write_EX = wr_op; funct3_EX = f3;
        alu_result_EX = addr; rs2_data_EX = rs2; rd_EX = rd; reg_write_EX = rw;
        rf_wr_sel_EX = sel; pc_EX = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_ex(); dmem_ack = 1'b0; dmem_rdata = '0;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({dmem_req, stall_MEM, reg_write_MEM, dmem_err_MEM, rd_MEM, rf_wr_sel_MEM,
             dmem_wstrb} !== 19'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want 0", {dmem_req, stall_MEM,
                reg_write_MEM, dmem_err_MEM, rd_MEM, rf_wr_sel_MEM, dmem_wstrb});
        end
        n_cmp++;
        if ({alu_result_MEM, mem_data_MEM, pc_MEM, dmem_addr} !== 256'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", alu_result_MEM,
                mem_data_MEM, pc_MEM, dmem_addr);
        end
        // Reset in the middle of an access.
        present(1'b1, 1'b0, 3'b011, 64'h1000, '0, 5'd9, 1'b1, 2'b11, 64'h80);
        step(); clear_ex();
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_req: got %b want 1", dmem_req);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({dmem_req, stall_MEM, reg_write_MEM} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_access: got %b want 000",
                {dmem_req, stall_MEM, reg_write_MEM});
        end
        step();
        reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
        step();
        dmem_ack = 1'b0;
        n_cmp++;
        if ({reg_write_MEM, dmem_req, stall_MEM, rd_MEM} !== 8'd0 || mem_data_MEM !== 64'd0)
        begin
            n_fail++; $display("FAIL late_ack_ignored: got rw=%b req=%b rd=%0d data=%h want 0",
                reg_write_MEM, dmem_req, rd_MEM, mem_data_MEM);
        end
    endtask

    task automatic test_alu();
        int stall_seen = 0;
        present(1'b0, 1'b0, 3'b000, 64'h1234, '0, 5'd5, 1'b1, 2'b10, 64'h100);
        #1 stall_seen += int'(stall_MEM);
        step(); clear_ex();
        stall_seen += int'(stall_MEM);
        n_cmp++;
        if ({rd_MEM, reg_write_MEM, rf_wr_sel_MEM} !== {5'd5, 1'b1, 2'b10} ||
            alu_result_MEM !== 64'h1234 || pc_MEM !== 64'h100) begin
            n_fail++; $display("FAIL alu_retire: got rd=%0d rw=%b sel=%b alu=%h pc=%h",
                rd_MEM, reg_write_MEM, rf_wr_sel_MEM, alu_result_MEM, pc_MEM);
        end
        step();
        stall_seen += int'(stall_MEM);
        n_cmp++;
        if (reg_write_MEM !== 1'b0 || rd_MEM !== 5'd5) begin
            n_fail++; $display("FAIL alu_bubble: got rw=%b rd=%0d want 0 5",
                reg_write_MEM, rd_MEM);
        end
        n_cmp++;
        if (stall_seen !== 0) begin
            n_fail++; $display("FAIL alu_no_stall: got %0d stall cycles want 0", stall_seen);
        end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [63:0] exp);
        int stall_cnt = 0;
        present(1'b1, 1'b0, f3, 64'h1003, '0, 5'd7, 1'b1, 2'b11, 64'h200);
        step(); clear_ex();
        n_cmp++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h1000) begin
            n_fail++; $display("FAIL load_req: got req=%b we=%b addr=%h", dmem_req, dmem_we,
                dmem_addr);
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                dmem_ack = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
            end
            #1 stall_cnt += int'(stall_MEM);
            if (c < 2 && reg_write_MEM !== 1'b0) begin
                n_cmp++; n_fail++; $display("FAIL load_early_rw: got 1 want 0");
            end
            step();
        end
        dmem_ack = 1'b0;
        n_cmp++;
        if (stall_cnt !== 2) begin
            n_fail++; $display("FAIL load_stall_cycles: got %0d want 2", stall_cnt);
        end
        n_cmp++;
        if (mem_data_MEM !== exp || reg_write_MEM !== 1'b1 || rd_MEM !== 5'd7 ||
            dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL load_byte f3=%b: got data=%h rw=%b rd=%0d req=%b want %h",
                f3, mem_data_MEM, reg_write_MEM, rd_MEM, dmem_req, exp);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t [6];
        logic [63:0] addr_t [6];
        logic [63:0] rdata_t [6];
        logic [63:0] exp_t [6];
        f3_t    = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111};
        addr_t  = '{64'h1006, 64'h1006, 64'h1004, 64'h1004, 64'h1008, 64'h1000};
        rdata_t = '{64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_t   = '{64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                    64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                    64'h0123_4567_89AB_CDEF, 64'h0};
        for (int i = 0; i < 6; i++) begin
            present(1'b1, 1'b0, f3_t[i], addr_t[i], '0, 5'd10, 1'b1, 2'b11, 64'h240);
            step(); clear_ex();
            dmem_ack = 1'b1; dmem_rdata = rdata_t[i];
            step();
            dmem_ack = 1'b0;
            n_cmp++;
            if (mem_data_MEM !== exp_t[i] || reg_write_MEM !== 1'b1) begin
                n_fail++; $display("FAIL load_ext[%0d]: got %h rw=%b want %h", i,
                    mem_data_MEM, reg_write_MEM, exp_t[i]);
            end
        end
        // Read and write both set: performed as LBU.
        present(1'b1, 1'b1, 3'b100, 64'h1001, 64'hFF, 5'd11, 1'b1, 2'b11, 64'h260);
        step(); clear_ex();
        n_cmp++;
        if (dmem_we !== 1'b0 || dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL rw_as_load_we: got we=%b req=%b want 0 1", dmem_we,
                dmem_req);
        end
        dmem_ack = 1'b1; dmem_rdata = 64'h7F00;
        step();
        dmem_ack = 1'b0;
        n_cmp++;
        if (mem_data_MEM !== 64'h7F) begin
            n_fail++; $display("FAIL rw_as_load_data: got %h want 7f", mem_data_MEM);
        end
    endtask

    task automatic test_store();
        present(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd0, 1'b0, 2'b00, 64'h500);
        for (int c = 0; c < 2; c++) begin
            step(); clear_ex();
            n_cmp++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h2000 ||
                dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'hABCD_0000_0000_0000) begin
                n_fail++; $display("FAIL sh_port[%0d]: got req=%b we=%b a=%h s=%h d=%h", c,
                    dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
            end
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        n_cmp++;
        if (dmem_req !== 1'b0 || reg_write_MEM !== 1'b0 || pc_MEM !== 64'h500) begin
            n_fail++; $display("FAIL sh_done: got req=%b rw=%b pc=%h want 0 0 500", dmem_req,
                reg_write_MEM, pc_MEM);
        end
        present(1'b0, 1'b1, 3'b000, 64'h3005, 64'h1234_5678_9ABC_DE5A, 5'd0, 1'b0, 2'b00,
                64'h504);
        step(); clear_ex();
        n_cmp++;
        if (dmem_addr !== 64'h3000 || dmem_wstrb !== 8'h20 ||
            dmem_wdata !== 64'h5A5A_5A5A_5A5A_5A5A) begin
            n_fail++; $display("FAIL sb_port: got a=%h s=%h d=%h", dmem_addr, dmem_wstrb,
                dmem_wdata);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
    endtask

`ifndef MISALIGN_TRAP_EN
    task automatic test_masking();
        present(1'b0, 1'b1, 3'b010, 64'h1002, 64'hCAFE_BABE, 5'd0, 1'b0, 2'b00, 64'h600);
        step(); clear_ex();
        n_cmp++;
        if (dmem_addr !== 64'h1000 || dmem_wstrb !== 8'h0F || dmem_wdata !== 64'hCAFE_BABE)
        begin
            n_fail++; $display("FAIL sw_masked: got a=%h s=%h d=%h", dmem_addr, dmem_wstrb,
                dmem_wdata);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        present(1'b1, 1'b0, 3'b010, 64'h1006, '0, 5'd12, 1'b1, 2'b11, 64'h604);
        step(); clear_ex();
        dmem_ack = 1'b1; dmem_rdata = 64'h1122_3344_5566_7788;
        step();
        dmem_ack = 1'b0;
        n_cmp++;
        if (mem_data_MEM !== 64'h1122_3344) begin
            n_fail++; $display("FAIL lw_masked: got %h want 11223344", mem_data_MEM);
        end
    endtask
`endif

    task automatic test_back_to_back();
        present(1'b1, 1'b0, 3'b011, 64'h1000, '0, 5'd3, 1'b1, 2'b11, 64'h300);
        step();
        present(1'b0, 1'b0, 3'b000, 64'h55, '0, 5'd4, 1'b1, 2'b10, 64'h304);
        dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
        #1;
        n_cmp++;
        if (stall_MEM !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ack_stall: got %b want 0", stall_MEM);
        end
        step();
        clear_ex(); dmem_ack = 1'b0;
        n_cmp++;
        if (reg_write_MEM !== 1'b1 || rd_MEM !== 5'd3 || mem_data_MEM !== 64'hDEAD) begin
            n_fail++; $display("FAIL b2b_load: got rw=%b rd=%0d data=%h want 1 3 dead",
                reg_write_MEM, rd_MEM, mem_data_MEM);
        end
        step();
        n_cmp++;
        if (reg_write_MEM !== 1'b1 || rd_MEM !== 5'd4 || alu_result_MEM !== 64'h55 ||
            pc_MEM !== 64'h304) begin
            n_fail++; $display("FAIL b2b_alu: got rw=%b rd=%0d alu=%h pc=%h", reg_write_MEM,
                rd_MEM, alu_result_MEM, pc_MEM);
        end
        step();
        n_cmp++;
        if (reg_write_MEM !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_dup: got rw=1 want 0");
        end
    endtask

    task automatic test_timeout();
        int err_at = -1;
        logic rw_seen = 1'b0;
        reset = 1'b1; clear_ex();
        step();
        reset = 1'b0;
        present(1'b1, 1'b0, 3'b010, 64'h1000, '0, 5'd13, 1'b1, 2'b11, 64'h700);
        for (int i = 1; i <= 8; i++) begin
            step(); clear_ex();
            rw_seen |= to_reg_write;
            if (to_err === 1'b1 && err_at < 0) err_at = i;
        end
        n_cmp++;
        if (err_at !== 5) begin
            n_fail++; $display("FAIL timeout_cycle: got %0d want 5", err_at);
        end
        n_cmp++;
        if (rw_seen !== 1'b0 || to_req !== 1'b0 || to_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: got rw=%b req=%b err=%b want 0 0 0",
                rw_seen, to_req, to_err);
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        reset = 1'b1; clear_ex();
        step();
        reset = 1'b0;
        present(1'b1, 1'b0, 3'b010, 64'h1002, '0, 5'd14, 1'b1, 2'b11, 64'h800);
        step(); clear_ex();
        n_cmp++;
        if (misalign_MEM !== 1'b1 || dmem_req !== 1'b0 || reg_write_MEM !== 1'b0 ||
            pc_MEM !== 64'h800) begin
            n_fail++; $display("FAIL misalign: got m=%b req=%b rw=%b pc=%h", misalign_MEM,
                dmem_req, reg_write_MEM, pc_MEM);
        end
        step();
        n_cmp++;
        if (misalign_MEM !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got m=%b req=%b want 0 0", misalign_MEM,
                dmem_req);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load_byte(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load_byte(3'b100, 64'h0000_0000_0000_0080);
        test_load_ext();
        test_store();
`ifndef MISALIGN_TRAP_EN
        test_masking();
`endif
        test_back_to_back();
        test_timeout();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
